// File: rtl/sha1_round_ctrl.sv
// SHA-1 compression sequencer: walks one block through work-variable load,
// ROUNDS round iterations (first WORDS paced by w_valid) and the chaining add.
module sha1_round_ctrl #(
    parameter int ROUNDS = 80,
    parameter int WORDS  = 16
) (
    input  logic       clk,
    input  logic       r,
    input  logic       blk_start,
    input  logic       first_blk,
    input  logic       w_valid,
    output logic       w_ready,
    input  logic       digest_ready,
    output logic       busy,
    output logic [6:0] t,
    output logic [1:0] fsel,
    output logic       w_sel,
    output logic       iv_load,
    output logic       work_load,
    output logic       round_en,
    output logic       hash_add,
    output logic       digest_valid
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [6:0] T_LAST  = 7'(ROUNDS - 1);
    localparam logic [7:0] N_WORDS = 8'(WORDS);
    localparam logic [7:0] Q1      = 8'(ROUNDS / 4);
    localparam logic [7:0] Q2      = 8'(ROUNDS / 2);
    localparam logic [7:0] Q3      = 8'((3 * ROUNDS) / 4);

    logic [2:0] state;
    logic       first_q;
    logic       in_round;
    logic       word_phase;
    logic [6:0] t_inc;

    // Quarter of the round range; evaluated on the next t so fsel never lags t.
    function automatic logic [1:0] quarter(input logic [6:0] x);
        logic [7:0] xe;
        xe = {1'b0, x};
        if (xe >= Q3)      quarter = 2'd3;
        else if (xe >= Q2) quarter = 2'd2;
        else if (xe >= Q1) quarter = 2'd1;
        else               quarter = 2'd0;
    endfunction

    assign in_round   = (state == S_ROUND);
    assign word_phase = ({1'b0, t} < N_WORDS);
    assign t_inc      = t + 7'd1;

    assign w_ready      = in_round & word_phase;
    assign w_sel        = in_round & ~word_phase;
    assign round_en     = in_round & (~word_phase | w_valid);
    assign work_load    = (state == S_INIT);
    assign iv_load      = (state == S_INIT) & first_q;
    assign hash_add     = (state == S_ADD);
    assign digest_valid = (state == S_DONE);
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (r) begin
            state   <= S_IDLE;
            t       <= '0;
            fsel    <= '0;
            first_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (blk_start) begin
                        first_q <= first_blk;
                        state   <= S_INIT;
                    end
                end
                S_INIT: begin
                    t     <= '0;
                    fsel  <= '0;
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    if (round_en) begin
                        if (t == T_LAST) begin
                            t     <= '0;
                            fsel  <= '0;
                            state <= S_ADD;
                        end else begin
                            t    <= t_inc;
                            fsel <= quarter(t_inc);
                        end
                    end
                end
                S_ADD: state <= S_DONE;
                S_DONE: begin
                    if (digest_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Directed bench for sha1_round_ctrl: full blocks, stalls, DONE back-pressure,
// mid-block reset and a held blk_start, with hand-derived cycle expectations.
module tb_sha1_round_ctrl;

    logic       clk = 1'b0;
    logic       r;
    logic       blk_start, first_blk, w_valid, digest_ready;
    logic       w_ready, busy, w_sel, iv_load, work_load, round_en, hash_add, digest_valid;
    logic [6:0] t;
    logic [1:0] fsel;

    int n_vec = 0;
    int n_bad = 0;

    sha1_round_ctrl dut (
        .clk(clk), .r(r), .blk_start(blk_start), .first_blk(first_blk),
        .w_valid(w_valid), .w_ready(w_ready), .digest_ready(digest_ready),
        .busy(busy), .t(t), .fsel(fsel), .w_sel(w_sel), .iv_load(iv_load),
        .work_load(work_load), .round_en(round_en), .hash_add(hash_add),
        .digest_valid(digest_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one block from IDLE. Rounds are walked cycle by cycle, so a wrong
    // latency shows up as a t/round_en/hash_add miscompare at the slipped cycle.
    task automatic run_block(input bit first, input int stall_t, input int stall_len,
                             input int dr_wait, input bit pulse_in_done,
                             input int abort_t, input bit hold_start);
        blk_start = 1'b1; first_blk = first; w_valid = 1'b1;
        digest_ready = (dr_wait == 0);
        #1;
        chk("idle_busy", busy, 0);
        step();
        blk_start = hold_start; first_blk = 1'b0;
        #1;
        chk("init_work_load", work_load, 1);
        chk("init_iv_load", iv_load, first);
        chk("init_round_en", round_en, 0);
        chk("init_busy", busy, 1);
        step();
        for (int k = 0; k < 80; k++) begin
            if (k == abort_t) begin
                r = 1'b1;
                step();
                r = 1'b0; blk_start = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_t", t, 0);
                chk("abort_fsel", fsel, 0);
                chk("abort_hash_add", hash_add, 0);
                chk("abort_round_en", round_en, 0);
                step();
                chk("abort_no_add", hash_add, 0);
                chk("abort_idle", busy, 0);
                return;
            end
            if (k == stall_t) begin
                for (int s = 0; s < stall_len; s++) begin
                    w_valid = 1'b0;
                    #1;
                    chk("stall_t", t, k);
                    chk("stall_round_en", round_en, 0);
                    chk("stall_w_ready", w_ready, 1);
                    step();
                end
            end
            w_valid = 1'b1;
            #1;
            chk("rnd_t", t, k);
            chk("rnd_round_en", round_en, 1);
            chk("rnd_fsel", fsel, k / 20);
            chk("rnd_w_sel", w_sel, (k >= 16));
            chk("rnd_w_ready", w_ready, (k < 16));
            chk("rnd_hash_add", hash_add, 0);
            chk("rnd_work_load", work_load, 0);
            step();
        end
        #1;
        chk("add_hash_add", hash_add, 1);
        chk("add_round_en", round_en, 0);
        chk("add_digest_valid", digest_valid, 0);
        chk("add_t", t, 0);
        step();
        for (int i = 0; i < dr_wait; i++) begin
            digest_ready = 1'b0;
            blk_start = hold_start | (pulse_in_done && i == 3);
            #1;
            chk("done_digest_valid", digest_valid, 1);
            chk("done_busy", busy, 1);
            chk("done_hash_add", hash_add, 0);
            step();
        end
        digest_ready = 1'b1; blk_start = hold_start;
        #1;
        chk("done_hs_valid", digest_valid, 1);
        step();
        digest_ready = 1'b0;
        #1;
        chk("post_digest_valid", digest_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        r = 1'b1; blk_start = 1'b0; first_blk = 1'b0; w_valid = 1'b0; digest_ready = 1'b0;
        repeat (3) step();
        r = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_t", t, 0);
        chk("rst_fsel", fsel, 0);
        chk("rst_hash_add", hash_add, 0);
        chk("rst_digest_valid", digest_valid, 0);
        chk("rst_work_load", work_load, 0);
        chk("rst_iv_load", iv_load, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_round_en", round_en, 0);
        chk("rst_w_sel", w_sel, 0);
        step();

        // Unstalled first block: hash_add 82 cycles after blk_start.
        run_block(1'b1, -1, 0, 0, 1'b0, -1, 1'b0);
        step();
        // Five-cycle stall at t=7: hash_add moves to cycle 87.
        run_block(1'b1, 7, 5, 0, 1'b0, -1, 1'b0);
        step();
        // Continuation block, digest held 10 cycles, stray blk_start in DONE.
        run_block(1'b0, -1, 0, 10, 1'b1, -1, 1'b0);
        blk_start = 1'b0;
        step();
        chk("done_pulse_ignored", busy, 0);
        // Reset at t=40, then a clean block.
        run_block(1'b1, -1, 0, 0, 1'b0, 40, 1'b0);
        run_block(1'b1, -1, 0, 0, 1'b0, -1, 1'b0);
        step();
        // blk_start held high: one block, then re-accepted only after IDLE.
        run_block(1'b1, -1, 0, 0, 1'b0, -1, 1'b1);
        step();
        chk("hold_reaccept_busy", busy, 1);
        chk("hold_reaccept_init", work_load, 1);
        r = 1'b1; blk_start = 1'b0;
        step();
        r = 1'b0;
        #1;
        chk("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
